// File: rtl/hilo_muldiv_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : hilo_muldiv_ctrl_pkg
// Purpose : Shared ALU op codes, mul/div sequencer state encoding and small
//           helpers for the HI/LO multi-cycle mul/div block.
// Ports   : (package, no ports)
// Revision: 1.0 - initial release
// ============================================================================
package hilo_muldiv_ctrl_pkg;

  localparam int MD_DATA_W = 32;
  localparam int MD_ITERS  = 32;
  localparam int ALUOP_W   = 5;

  // ALU op codes shared with the main ALU decoder
  localparam logic [ALUOP_W-1:0] ALUOP_MULT  = 5'h18;
  localparam logic [ALUOP_W-1:0] ALUOP_MULTU = 5'h19;
  localparam logic [ALUOP_W-1:0] ALUOP_DIV   = 5'h1A;
  localparam logic [ALUOP_W-1:0] ALUOP_DIVU  = 5'h1B;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_PREP = 2'd1,
    MD_ITER = 2'd2,
    MD_FIX  = 2'd3
  } md_state_e;

  function automatic logic is_md_op(input logic [ALUOP_W-1:0] op);
    return (op == ALUOP_MULT) || (op == ALUOP_MULTU) ||
           (op == ALUOP_DIV)  || (op == ALUOP_DIVU);
  endfunction

  function automatic logic is_div_op(input logic [ALUOP_W-1:0] op);
    return (op == ALUOP_DIV) || (op == ALUOP_DIVU);
  endfunction

  function automatic logic is_signed_op(input logic [ALUOP_W-1:0] op);
    return (op == ALUOP_MULT) || (op == ALUOP_DIV);
  endfunction

endpackage
`default_nettype wire

// File: rtl/hilo_muldiv_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : hilo_muldiv_ctrl_if
// Purpose : Request / result bundle between EX-stage control and the HI/LO
//           mul/div sequencer.
// Ports   : start_i, aluop_i, src0_i, src1_i, flush_i, wr_hi_i, wr_lo_i,
//           wdata_i (towards sequencer); hi_o, lo_o, busy_o, done_o, dz_o
//           (from sequencer).
// Revision: 1.0 - initial release
// ============================================================================
interface hilo_muldiv_ctrl_if #(
  parameter int DATA_W = 32
);
  import hilo_muldiv_ctrl_pkg::*;

  logic               start_i;
  logic [ALUOP_W-1:0] aluop_i;
  logic [DATA_W-1:0]  src0_i;
  logic [DATA_W-1:0]  src1_i;
  logic               flush_i;
  logic               wr_hi_i;
  logic               wr_lo_i;
  logic [DATA_W-1:0]  wdata_i;
  logic [DATA_W-1:0]  hi_o;
  logic [DATA_W-1:0]  lo_o;
  logic               busy_o;
  logic               done_o;
  logic               dz_o;

  modport master (
    output start_i, aluop_i, src0_i, src1_i, flush_i, wr_hi_i, wr_lo_i, wdata_i,
    input  hi_o, lo_o, busy_o, done_o, dz_o
  );

  modport slave (
    input  start_i, aluop_i, src0_i, src1_i, flush_i, wr_hi_i, wr_lo_i, wdata_i,
    output hi_o, lo_o, busy_o, done_o, dz_o
  );

endinterface
`default_nettype wire

// File: rtl/hilo_muldiv_ctrl_muldiv_step.sv
`default_nettype none
// ============================================================================
// Module  : muldiv_step
// Purpose : One iteration of the shift-add multiplier / restoring divider.
//           Multiply: acc = {partial product hi, multiplier}, shifts right.
//           Divide  : acc = {remainder, dividend/quotient}, shifts left.
// Ports   : is_div (1=divide), acc (2*DATA_W), opnd (multiplicand or
//           divisor), acc_next (2*DATA_W, combinational).
// Revision: 1.0 - initial release
// ============================================================================
module muldiv_step #(
  parameter int DATA_W = 32
) (
  input  wire logic                  is_div,
  input  wire logic [2*DATA_W-1:0]   acc,
  input  wire logic [DATA_W-1:0]     opnd,
  output logic      [2*DATA_W-1:0]   acc_next
);

  logic [DATA_W:0] w_sum;
  logic [DATA_W:0] w_trial;

  always_comb begin
    w_sum    = {1'b0, acc[2*DATA_W-1:DATA_W]};
    w_trial  = acc[2*DATA_W-1:DATA_W-1] - {1'b0, opnd};
    acc_next = acc;
    if (acc[0]) begin
      // carry out lands in the top bit and is shifted back into acc[63]
      w_sum = {1'b0, acc[2*DATA_W-1:DATA_W]} + {1'b0, opnd};
    end
    if (is_div) begin
      // remainder < divisor, so bit DATA_W of the trial is a clean sign bit
      if (w_trial[DATA_W]) begin
        acc_next = {acc[2*DATA_W-2:0], 1'b0};
      end else begin
        acc_next = {w_trial[DATA_W-1:0], acc[DATA_W-2:0], 1'b1};
      end
    end else begin
      acc_next = {w_sum, acc[DATA_W-1:1]};
    end
  end

endmodule
`default_nettype wire

// File: rtl/hilo_muldiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : hilo_muldiv_ctrl
// Purpose : Multi-cycle MULT/MULTU/DIV/DIVU sequencer and owner of the HI/LO
//           registers; also services MTHI/MTLO writes while idle.
// Ports   : clk, rst (async, active-high), bus (hilo_muldiv_ctrl_if.slave):
//           request/operands/flush/MTHI-MTLO in, hi/lo/busy/done/dz out.
// Revision: 1.0 - initial release
// ============================================================================
module hilo_muldiv_ctrl
  import hilo_muldiv_ctrl_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 5
) (
  input wire logic          clk,
  input wire logic          rst,
  hilo_muldiv_ctrl_if.slave bus
);

  localparam logic [CNT_W-1:0] c_last_iter = CNT_W'(DATA_W - 1);

  md_state_e             r_state, w_state_nxt;
  logic [CNT_W-1:0]      r_cnt;
  logic [DATA_W-1:0]     r_src0, r_src1, r_opnd, r_hi, r_lo;
  logic [2*DATA_W-1:0]   r_acc;
  logic                  r_is_div, r_is_signed, r_sign_q, r_sign_r, r_div_zero;
  logic                  r_done, r_dz;

  logic                  w_accept, w_commit, w_mt_en, w_dz;
  logic [DATA_W-1:0]     w_abs0, w_abs1, w_hi_fix, w_lo_fix;
  logic [2*DATA_W-1:0]   w_acc_next, w_prod;

  muldiv_step #(.DATA_W(DATA_W)) u_step (
    .is_div   (r_is_div),
    .acc      (r_acc),
    .opnd     (r_opnd),
    .acc_next (w_acc_next)
  );

  assign w_abs0 = (r_is_signed && r_src0[DATA_W-1]) ? -r_src0 : r_src0;
  assign w_abs1 = (r_is_signed && r_src1[DATA_W-1]) ? -r_src1 : r_src1;
  assign w_dz   = r_is_div && (r_src1 == '0);
  assign w_prod = r_sign_q ? -r_acc : r_acc;

  always_comb begin
    w_hi_fix = w_prod[2*DATA_W-1:DATA_W];
    w_lo_fix = w_prod[DATA_W-1:0];
    if (r_div_zero) begin
      w_hi_fix = r_src0;
      w_lo_fix = '1;
    end else if (r_is_div) begin
      w_hi_fix = r_sign_r ? -r_acc[2*DATA_W-1:DATA_W] : r_acc[2*DATA_W-1:DATA_W];
      w_lo_fix = r_sign_q ? -r_acc[DATA_W-1:0] : r_acc[DATA_W-1:0];
    end
  end

  // next-state and control strobes
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_commit    = 1'b0;
    w_mt_en     = 1'b0;
    case (r_state)
      MD_IDLE: begin
        if (bus.start_i && is_md_op(bus.aluop_i)) begin
          w_state_nxt = MD_PREP;
          w_accept    = 1'b1;
        end else begin
          w_mt_en = bus.wr_hi_i || bus.wr_lo_i;
        end
      end
      MD_PREP: w_state_nxt = w_dz ? MD_FIX : MD_ITER;
      MD_ITER: if (r_cnt == c_last_iter) w_state_nxt = MD_FIX;
      MD_FIX: begin
        w_state_nxt = MD_IDLE;
        w_commit    = 1'b1;
      end
      default: w_state_nxt = MD_IDLE;
    endcase
    if (bus.flush_i && (r_state != MD_IDLE)) begin
      w_state_nxt = MD_IDLE;
      w_commit    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= MD_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt       <= '0;
      r_src0      <= '0;
      r_src1      <= '0;
      r_opnd      <= '0;
      r_acc       <= '0;
      r_hi        <= '0;
      r_lo        <= '0;
      r_is_div    <= 1'b0;
      r_is_signed <= 1'b0;
      r_sign_q    <= 1'b0;
      r_sign_r    <= 1'b0;
      r_div_zero  <= 1'b0;
      r_done      <= 1'b0;
      r_dz        <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_dz   <= 1'b0;
      if (w_accept) begin
        r_src0      <= bus.src0_i;
        r_src1      <= bus.src1_i;
        r_is_div    <= is_div_op(bus.aluop_i);
        r_is_signed <= is_signed_op(bus.aluop_i);
      end
      if (r_state == MD_PREP) begin
        r_sign_q   <= r_is_signed && (r_src0[DATA_W-1] ^ r_src1[DATA_W-1]);
        r_sign_r   <= r_is_signed && r_src0[DATA_W-1];
        r_div_zero <= w_dz;
        r_cnt      <= '0;
        // divide: divisor in opnd, dividend in acc low; multiply: the reverse
        r_opnd     <= r_is_div ? w_abs1 : w_abs0;
        r_acc      <= {{DATA_W{1'b0}}, (r_is_div ? w_abs0 : w_abs1)};
      end
      if (r_state == MD_ITER) begin
        r_cnt <= r_cnt + 1'b1;
        r_acc <= w_acc_next;
      end
      if (w_commit) begin
        r_hi   <= w_hi_fix;
        r_lo   <= w_lo_fix;
        r_done <= 1'b1;
        r_dz   <= r_div_zero;
      end
      if (w_mt_en) begin
        if (bus.wr_hi_i) r_hi <= bus.wdata_i;
        if (bus.wr_lo_i) r_lo <= bus.wdata_i;
      end
    end
  end

  assign bus.hi_o   = r_hi;
  assign bus.lo_o   = r_lo;
  assign bus.busy_o = (r_state != MD_IDLE);
  assign bus.done_o = r_done;
  assign bus.dz_o   = r_dz;

endmodule
`default_nettype wire

// File: doc/hilo_muldiv_ctrl.md
Name: hilo_muldiv_ctrl

Overview:
- Multi-cycle sequencer and HI/LO register owner for MULT/MULTU/DIV/DIVU.
- Sits beside the single-cycle ALU in EX; replaces the combinational 64-bit mul/div path with a 32-iteration shift-add / restoring-divide engine.
- Exposes busy/done handshake so pipeline control stalls dependent MFHI/MFLO and later mul/div.
- Also services MTHI/MTLO writes.

Parameters:
- DATA_W, 32, operand width (HI/LO each DATA_W; only 32 supported/verified)
- CNT_W, 5, iteration counter width (log2 DATA_W)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start_i  in  1  request, sampled only in IDLE
- aluop_i  in  5  ALUOP_* code from defines.v; accepted: MULT, MULTU, DIV, DIVU
- src0_i  in  32  rs: multiplicand / dividend
- src1_i  in  32  rt: multiplier / divisor
- flush_i  in  1  abort in-flight op
- wr_hi_i  in  1  MTHI strobe
- wr_lo_i  in  1  MTLO strobe
- wdata_i  in  32  MTHI/MTLO data
- hi_o  out  32  HI register (remainder / product[63:32])
- lo_o  out  32  LO register (quotient / product[31:0])
- busy_o  out  1  state != IDLE (decoded from state register)
- done_o  out  1  one-cycle pulse, HI/LO just updated
- dz_o  out  1  divide-by-zero flag, valid with done_o

Behaviour:
- Reset (async, rst=1): state=IDLE, hi_o=lo_o=0, done_o=0, dz_o=0, counter=0, operand/acc regs=0. Deassertion mid-op: stays in IDLE, no done.
- States: IDLE, PREP, ITER, FIX.
- IDLE: start_i=1 with accepted aluop -> latch ops/op, go PREP. Other aluop with start_i -> ignored, stays IDLE.
- PREP: signed ops take abs values (two's-complement negate when bit31=1); record sign_q=src0[31]^src1[31], sign_r=src0[31].
  - DIV/DIVU with divisor==0 -> FIX with dz set.
  - Otherwise -> ITER, cnt=0.
- ITER, one bit/cycle:
  - Multiply: 64-bit acc; if multiplier lsb, add multiplicand to acc[63:32] (33-bit carry kept); shift acc/multiplier right 1.
  - Divide: restoring; trial = {rem[31:0],dividend msb} - {1'b0,divisor} (33-bit); non-negative -> rem=trial, quotient bit 1; else shift only, bit 0.
  - cnt==31 -> FIX; else cnt+1.
- FIX: apply signs; write hi/lo; done_o=1 for exactly one cycle; -> IDLE.
  - MULT: negate 64-bit product if sign_q.
  - DIV: negate quotient if sign_q; negate remainder if sign_r.
  - Divide-by-zero: HI=src0 unchanged, LO=32'hFFFF_FFFF, dz_o=1.
- Latency: start sampled at edge N -> done_o high after edge N+34 (busy N+1..N+34 edges). Divide-by-zero: done after edge N+2.
- DIV 0x8000_0000 / -1: LO=0x8000_0000, HI=0, no flag.
- start_i while busy: ignored; the caller must hold the request.
- flush_i: highest priority after rst. In any non-IDLE state -> IDLE next edge; HI/LO unchanged; no done_o. Flush in FIX suppresses the write.
- MTHI/MTLO: in IDLE, write at next edge. Both strobes allowed together; both take wdata_i. While busy: dropped.
- Same-cycle start_i + wr strobe in IDLE: start wins, write dropped.
- Back-to-back: new start accepted in the cycle done_o is high (state IDLE).

Decomposition:
- defines.v gains state codes MD_IDLE/MD_PREP/MD_ITER/MD_FIX (2-bit) and MD_ITERS=32. Existing ALUOP_* codes reused.
- One combinational sub-module, muldiv_step: computes the next acc/rem/quotient for one iteration given op type. The controller holds FSM, counter, sign fixup and HI/LO.

Test Plan:
- MULT src0=-3 (FFFFFFFD), src1=5 -> after 34 edges: done_o=1, HI=FFFFFFFF, LO=FFFFFFF1, busy_o low same cycle.
- MULTU FFFFFFFF x FFFFFFFF -> HI=FFFFFFFE, LO=00000001. DIVU 7/2 -> HI=1, LO=3.
- DIV -7/2 -> HI=FFFFFFFF, LO=FFFFFFFD. DIV 80000000/FFFFFFFF -> HI=0, LO=80000000, dz_o=0.
- DIVU 100/0 -> done after 2 edges, HI=00000064, LO=FFFFFFFF, dz_o=1.
- Start DIV; flush_i at edge N+10 -> busy_o low next cycle, HI/LO hold prior values, no done_o. Next start completes normally.
- MTHI 0xA5A5A5A5 while busy -> dropped; in IDLE -> hi_o=A5A5A5A5 next edge. rst asserted at edge N+20 mid-MULT -> immediate IDLE, hi_o=lo_o=0.
